// File: rtl/adder_pkg.sv
// Shared definitions for the word-serial adder: FSM state encoding and index sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word index width; a single-word operand still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/n_bit_adder.sv
// Combinational N-bit ripple-carry adder shared across all words of a wide add.
module n_bit_adder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum_c,
    output logic         cout_c
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum_c[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout_c = carry[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide (N*M-bit) adder built from one N-bit adder stepped over M cycles, LS word first.
module multiword_add_seq
    import adder_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*M-1:0] A,
    input  logic [N*M-1:0] B,
    input  logic           Cin,
    output logic           busy,
    output logic           done,
    output logic [N*M-1:0] Sum,
    output logic           Cout
);

    localparam int unsigned W  = N * M;
    localparam int unsigned IW = idx_width(M);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   sum_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_d;
    logic           busy_d;
    logic           done_d;

    logic [N-1:0]   a_word;
    logic [N-1:0]   b_word;
    logic [N-1:0]   add_sum;
    logic           add_cout;

    // Select the operand words addressed by idx
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned w = 0; w < M; w++) begin
            if (idx_q == IW'(w)) begin
                a_word = a_q[w*N +: N];
                b_word = b_q[w*N +: N];
            end
        end
    end

    n_bit_adder #(
        .N (N)
    ) u_adder (
        .a      (a_word),
        .b      (b_word),
        .cin    (carry_q),
        .sum_c  (add_sum),
        .cout_c (add_cout)
    );

    // Next-state and next-register values
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = Sum;
        cout_d  = Cout;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < M; w++) begin
                    if (idx_q == IW'(w)) begin
                        acc_d[w*N +: N] = add_sum;
                    end
                end
                carry_d = add_cout;
                idx_d   = idx_q + IW'(1);
                // Last word: publish the whole accumulation at once
                if (idx_q == IW'(M - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            Sum     <= sum_d;
            Cout    <= cout_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=4, M=4) against a plain wide-add reference.
module tb_multiword_add_seq;

    localparam int unsigned N = 4;
    localparam int unsigned M = 4;
    localparam int unsigned W = N * M;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    int unsigned  tests;
    int unsigned  fails;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    multiword_add_seq #(
        .N (N),
        .M (M)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation; reference result is a single wide add. hold keeps start high,
    // noise drives a competing request during RUN.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input bit hold, input bit noise, input string tag);
        logic [W:0] ref_full;
        ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            Cin = 1'($urandom);
        end
        check({tag, ":busy_t0"}, 32'(busy), 32'd1);
        check({tag, ":hold_sum"}, 32'(Sum), 32'(prev_sum));
        check({tag, ":hold_cout"}, 32'(Cout), 32'(prev_cout));
        for (int k = 1; k < int'(M); k++) begin
            if (noise) begin
                start = 1'b1; A = '1; B = '1;
            end
            @(posedge clk); #1;
            check({tag, ":busy_run"}, 32'(busy), 32'd1);
            check({tag, ":nodone_run"}, 32'(done), 32'd0);
        end
        if (noise) start = 1'b0;
        @(posedge clk); #1;
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":busy_done"}, 32'(busy), 32'd0);
        check({tag, ":sum"}, 32'(Sum), 32'(ref_full[W-1:0]));
        check({tag, ":cout"}, 32'(Cout), 32'(ref_full[W]));
        prev_sum  = ref_full[W-1:0];
        prev_cout = ref_full[W];
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ":idle_done"}, 32'(done), 32'd0);
        check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        tests = 0; fails = 0;
        prev_sum = '0; prev_cout = 1'b0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;

        #12;
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:sum", 32'(Sum), 32'd0);
        check("rst:cout", 32'(Cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "t1");
        idle_cycle("t1");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "t2");
        idle_cycle("t2");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, "t3a");
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "t3b");
        idle_cycle("t3");
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, "t4");
        idle_cycle("t4");

        // Abort mid-RUN with reset
        @(negedge clk);
        A = 16'h8000; B = 16'h8000; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5:rst_sum", 32'(Sum), 32'd0);
        check("t5:rst_cout", 32'(Cout), 32'd0);
        check("t5:rst_busy", 32'(busy), 32'd0);
        check("t5:rst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("t5:no_done", 32'(done), 32'd0);
        end
        do_op(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, "t5");
        idle_cycle("t5");

        for (int k = 0; k < 3; k++) begin
            do_op(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, "t6");
        end
        idle_cycle("t6");

        for (int k = 0; k < 12; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, 1'b0, 1'b0, "rnd");
            if ($urandom_range(0, 1) == 0) idle_cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
